// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide, MTHI/MTLO.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU complete as single-cycle no-ops.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef MDU_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_FIX  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [4:0]         count;
  logic [WIDTH-1:0]   operand_reg;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;           // {product} or {remainder, quotient}
  logic               neg_result;

  logic               a_neg, b_neg, op_mul, last_iter;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod_fixed;

  // Even opcodes of the arithmetic group (MULT, DIV) are the signed ones.
  assign a_neg     = ~op[0] & operand_a[WIDTH-1];
  assign b_neg     = ~op[0] & operand_b[WIDTH-1];
  assign a_mag     = a_neg ? -operand_a : operand_a;
  assign b_mag     = b_neg ? -operand_b : operand_b;
  assign op_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign last_iter = (count == 5'd31);

  assign mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand_reg} : '0);
  assign mul_next   = {mul_sum, acc[WIDTH-1:1]};
  assign prod_fixed = neg_result ? -acc : acc;

`ifdef MDU_DIV_EN
  logic               is_div, neg_rem, div_zero, op_div;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fixed, rem_fixed;

  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, operand_reg};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
  // With a zero divisor the remainder ends up as |a|; re-applying the dividend
  // sign restores operand_a bit-exactly, so HI needs no special case.
  assign quo_fixed = div_zero ? '1 : (neg_result ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fixed = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && op_mul) state_next = S_MUL;
`ifdef MDU_DIV_EN
        else if (start && op_div) state_next = S_DIV;
`endif
      end
      S_MUL: begin
        busy = 1'b1;
        if (last_iter) state_next = S_FIX;
      end
`ifdef MDU_DIV_EN
      S_DIV: begin
        busy = 1'b1;
        if (last_iter) state_next = S_FIX;
      end
`endif
      S_FIX: begin
        busy       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      operand_reg <= '0;
      acc         <= '0;
      neg_result  <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
`ifdef MDU_DIV_EN
      is_div      <= 1'b0;
      neg_rem     <= 1'b0;
      div_zero    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                acc         <= {{WIDTH{1'b0}}, b_mag};
                operand_reg <= a_mag;
                neg_result  <= a_neg ^ b_neg;
                count       <= '0;
`ifdef MDU_DIV_EN
                is_div      <= 1'b0;
`endif
              end
              OP_DIV, OP_DIVU: begin
`ifdef MDU_DIV_EN
                acc         <= {{WIDTH{1'b0}}, a_mag};
                operand_reg <= b_mag;
                neg_result  <= a_neg ^ b_neg;
                neg_rem     <= a_neg;
                div_zero    <= (operand_b == '0);
                is_div      <= 1'b1;
                count       <= '0;
`else
                done        <= 1'b1;
`endif
              end
              OP_MTHI: begin
                hi   <= operand_a;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= operand_a;
                done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc   <= mul_next;
          count <= count + 5'd1;
        end
`ifdef MDU_DIV_EN
        S_DIV: begin
          acc   <= div_next;
          count <= count + 5'd1;
        end
`endif
        S_FIX: begin
          done <= 1'b1;
`ifdef MDU_DIV_EN
          if (is_div) begin
            hi <= rem_fixed;
            lo <= quo_fixed;
          end else begin
            hi <= prod_fixed[2*WIDTH-1:WIDTH];
            lo <= prod_fixed[WIDTH-1:0];
          end
`else
          hi <= prod_fixed[2*WIDTH-1:WIDTH];
          lo <= prod_fixed[WIDTH-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized ops
// checked against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, busy, done;
  logic [2:0]  op;
  logic [31:0] operand_a, operand_b, hi, lo;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi, m_lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: updates m_hi/m_lo; kind = 1 iterative, 0 single-cycle, -1 ignored.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int kind);
    int sa, sb;
    longint p;
    logic [63:0] pu;
    sa = a;
    sb = b;
    kind = 0;
    case (o)
      3'd0: begin p = longint'(sa) * longint'(sb); {m_hi, m_lo} = p; kind = 1; end
      3'd1: begin pu = {32'h0, a} * {32'h0, b}; {m_hi, m_lo} = pu; kind = 1; end
      3'd2, 3'd3: begin
`ifdef MDU_DIV_EN
        kind = 1;
        if (b == 32'h0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else if (o == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'h0;
        end else if (o == 3'd2) begin
          m_lo = sa / sb;
          m_hi = sa % sb;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
`endif
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: kind = -1;
    endcase
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op, scrambles operands and pokes start while busy, then checks timing and HI/LO.
  task automatic do_op(input string name, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    int kind, n, busy_err;
    model(o, a, b, kind);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    n = 0;
    busy_err = 0;
    if (kind < 0) begin
      repeat (3) begin
        if (done !== 1'b0 || busy !== 1'b0) busy_err++;
        tick();
      end
      check({name, "/ignored"}, 64'(busy_err), 64'd0);
    end else begin
      while (done !== 1'b1 && n < 40) begin
        if (busy !== 1'b1) busy_err++;
        if ($urandom_range(0, 3) == 0) begin
          start = 1'b1;
          op = 3'($urandom_range(0, 5));
        end else begin
          start = 1'b0;
        end
        tick();
        n++;
      end
      start = 1'b0;
      check({name, "/latency"}, 64'(n), (kind == 1) ? 64'd33 : 64'd0);
      check({name, "/busy_run"}, 64'(busy_err), 64'd0);
      check({name, "/busy_at_done"}, 64'(busy), 64'd0);
    end
    check({name, "/hi"}, 64'(hi), 64'(m_hi));
    check({name, "/lo"}, 64'(lo), 64'(m_lo));
  endtask

  initial begin
    int seen_done;
    reset = 1'b1; start = 1'b0; op = 3'd0; operand_a = '0; operand_b = '0;
    repeat (3) tick();
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/done", 64'(done), 64'd0);
    check("reset/hi", 64'(hi), 64'd0);
    check("reset/lo", 64'(lo), 64'd0);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    tick();

    do_op("multu_ff",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_ff/hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_ff/lo_const", 64'(lo), 64'h0000_0000_0000_0001);
    do_op("mult_neg",   3'd0, 32'hFFFF_FFFD, 32'h0000_0005);
    do_op("mult_min",   3'd0, 32'h8000_0000, 32'h8000_0000);
    do_op("div_neg",    3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    do_op("div_ovf",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("divu_zero",  3'd3, 32'h0000_0007, 32'h0000_0000);
    do_op("div_zero",   3'd2, 32'hFFFF_FFF0, 32'h0000_0000);
    do_op("mthi",       3'd4, 32'h1234_5678, 32'h0);
    do_op("mtlo",       3'd5, 32'h9ABC_DEF0, 32'h0);
    tick();
    check("done_pulse", 64'(done), 64'd0);
    do_op("reserved6",  3'd6, 32'hDEAD_BEEF, 32'h1);
    do_op("reserved7",  3'd7, 32'hCAFE_F00D, 32'h2);

    for (int i = 0; i < 40; i++) begin
      do_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 6)), pick(), pick());
    end

    // Reset in the middle of a multiply, with a stray start while busy.
    op = 3'd1; operand_a = 32'd3; operand_b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    seen_done = 0;
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin
        start = 1'b1; operand_a = 32'd7; operand_b = 32'd9;
      end else begin
        start = 1'b0;
      end
      if (done !== 1'b0) seen_done++;
      tick();
    end
    check("mid/busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    for (int c = 0; c < 3; c++) begin
      if (done !== 1'b0) seen_done++;
      tick();
    end
    check("mid/no_done", 64'(seen_done), 64'd0);
    check("mid/busy", 64'(busy), 64'd0);
    check("mid/hi", 64'(hi), 64'd0);
    check("mid/lo", 64'(lo), 64'd0);
    do_op("fresh_multu", 3'd1, 32'd3, 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
